fifo_ctrl_16x4: RTL and testbench
=================================

FIFO_CTRL_16X4 -- requirements
Module: fifo_ctrl_16x4

Interface
REQ-001 Parameter DATA_WIDTH, default 4, SHALL set the data width of all data ports.
REQ-002 Parameter ADDR_WIDTH, default 4, SHALL set the memory address width.
REQ-003 Parameter DEPTH, default 16, SHALL equal 2**ADDR_WIDTH and set the entry count.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-006 wr_req  input  1  SHALL be the producer write request.
REQ-007 wr_data  input  DATA_WIDTH  SHALL be the producer write data.
REQ-008 rd_req  input  1  SHALL be the consumer read request.
REQ-009 rd_data  output  DATA_WIDTH  SHALL be the registered read data to the consumer.
REQ-010 rd_valid  output  1  SHALL pulse for one cycle when rd_data holds new data.
REQ-011 full, empty  output  1 each  SHALL be the registered status flags.
REQ-012 count  output  ADDR_WIDTH+1  SHALL be the registered occupancy, 0..DEPTH.
REQ-013 overflow, underflow  output  1 each  SHALL be sticky error flags.
REQ-014 mem_wr_en, mem_wr_addr (ADDR_WIDTH), mem_wr_data (DATA_WIDTH)  output  SHALL drive the memory write port.
REQ-015 mem_rd_en, mem_rd_addr (ADDR_WIDTH)  output  SHALL drive the memory read port; mem_rd_data (DATA_WIDTH) input SHALL return the read word.

Function
REQ-016 A write SHALL be accepted when wr_req=1 and full=0; mem_wr_en=wr_req&~full, mem_wr_addr=wr_ptr[ADDR_WIDTH-1:0], mem_wr_data=wr_data, all combinational.
REQ-017 A read SHALL be accepted when rd_req=1 and empty=0; mem_rd_en=rd_req&~empty, mem_rd_addr=rd_ptr[ADDR_WIDTH-1:0].
REQ-018 wr_ptr and rd_ptr SHALL be ADDR_WIDTH+1 bits, increment by one per accepted operation, and wrap from 2*DEPTH-1 to 0.
REQ-019 count SHALL be +1 on write-only, -1 on read-only, unchanged on simultaneous accepted read and write or no operation.
REQ-020 full SHALL be 1 exactly when count=DEPTH; empty SHALL be 1 exactly when count=0.
REQ-021 When full, a write SHALL be rejected even if a read is accepted in the same cycle.
REQ-022 When empty, a read SHALL be rejected even if a write is accepted in the same cycle (no fall-through).
REQ-023 mem_rd_data SHALL be sampled in the cycle after an accepted read and registered into rd_data, with rd_valid=1 in that cycle (read latency 2 cycles from request to rd_data visible after the edge).
REQ-024 rd_data SHALL hold its last value when no read completes.
REQ-025 overflow SHALL set on wr_req=1 while full=1; underflow SHALL set on rd_req=1 while empty=1; both SHALL stay set until reset.
REQ-026 Rejected requests SHALL leave pointers, count and memory unchanged.

Reset
REQ-027 rst=1 SHALL immediately clear wr_ptr, rd_ptr, count, rd_data, rd_valid, overflow, underflow and set empty=1, full=0, regardless of clk.
REQ-028 Reset mid-operation SHALL discard any pending read completion; rd_valid SHALL be 0 in the first cycle after reset release.
REQ-029 Memory contents SHALL NOT be cleared by reset.

Structure
REQ-030 DATA_WIDTH, ADDR_WIDTH, DEPTH defaults and the count width constant SHALL live in shared package fifo_pkg.
REQ-031 The block SHALL contain no sub-module; storage SHALL be the existing memory_16x4, instantiated by the parent beside this controller.

Verification
REQ-032 Reset then idle -> empty=1, full=0, count=0, rd_valid=0, no mem_wr_en/mem_rd_en.
REQ-033 Write 0x1..0xF,0x0 (16 writes) -> full=1, count=16; 17th write rejected, overflow=1, count stays 16.
REQ-034 After fill, 16 reads -> rd_data sequence 0x1..0xF,0x0 with one rd_valid each; empty=1; extra read sets underflow=1.
REQ-035 Count=8, simultaneous wr_req/rd_req for 20 cycles -> count stays 8, pointers wrap past 31, data order preserved.
REQ-036 Empty with simultaneous wr_req=1 (0xA) and rd_req=1 -> write accepted, read rejected, count=1, underflow=1; next read returns 0xA.
REQ-037 Assert rst one cycle after accepted read -> rd_valid never pulses, count=0, empty=1 asynchronously.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared sizing constants and operation encoding for the 16x4 FIFO controller.
package fifo_pkg;

  localparam int FIFO_DATA_W = 4;
  localparam int FIFO_ADDR_W = 4;
  localparam int FIFO_DEPTH  = 16;
  localparam int FIFO_CNT_W  = FIFO_ADDR_W + 1;

  // Accepted operation in a cycle, encoded as {write, read}
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_RW   = 2'b11
  } op_e;

endpackage

// File: rtl/fifo_ctrl_16x4.sv
// FIFO controller for an external synchronous-read memory_16x4: pointers, occupancy,
// registered status/error flags and a two-cycle registered read return path.
module fifo_ctrl_16x4
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_W,
  parameter int ADDR_WIDTH = FIFO_ADDR_W,
  parameter int DEPTH      = FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_req,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_req,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);

  localparam int CNT_W = ADDR_WIDTH + 1;

  logic [CNT_W-1:0] wr_ptr, rd_ptr, count_nxt;
  logic             wr_acc, rd_acc;
  op_e              op;
  // [0]: memory read issued last cycle, [1]: rd_data freshly loaded
  logic [1:0]       vld_pipe;

  assign wr_acc      = wr_req & ~full;
  assign rd_acc      = rd_req & ~empty;
  assign op          = op_e'({wr_acc, rd_acc});

  assign mem_wr_en   = wr_acc;
  assign mem_wr_addr = wr_ptr[ADDR_WIDTH-1:0];
  assign mem_wr_data = wr_data;
  assign mem_rd_en   = rd_acc;
  assign mem_rd_addr = rd_ptr[ADDR_WIDTH-1:0];
  assign rd_valid    = vld_pipe[1];

  always_comb begin
    count_nxt = count;
    unique case (op)
      OP_WR:   count_nxt = count + 1'b1;
      OP_RD:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Flags are registered from the next count so they line up with count itself
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      vld_pipe  <= '0;
      rd_data   <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      count     <= count_nxt;
      full      <= (count_nxt == CNT_W'(DEPTH));
      empty     <= (count_nxt == '0);
      overflow  <= overflow  | (wr_req & full);
      underflow <= underflow | (rd_req & empty);
      vld_pipe  <= {vld_pipe[0], rd_acc};
      if (vld_pipe[0]) rd_data <= mem_rd_data;
    end
  end

endmodule

// File: tb/tb_fifo_ctrl_16x4.sv
// Scoreboard bench: behavioral memory_16x4 beside the controller, queue-based reference model.
module tb_fifo_ctrl_16x4;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_req, rd_req;
  logic [3:0] wr_data, rd_data;
  logic       rd_valid, full, empty, overflow, underflow;
  logic [4:0] count;
  logic       mem_wr_en, mem_rd_en;
  logic [3:0] mem_wr_addr, mem_wr_data, mem_rd_addr, mem_rd_data;

  fifo_ctrl_16x4 dut (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .wr_data(wr_data),
    .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid),
    .full(full), .empty(empty), .count(count),
    .overflow(overflow), .underflow(underflow),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  // memory_16x4: synchronous write, registered read
  logic [3:0] mem [16];
  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
  end

  typedef struct {
    logic [3:0] data;
    int         cyc;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] mq[$];
  logic [4:0] m_wp, m_rp;
  logic       m_ovf, m_unf;
  int         ncyc = 0;
  int         n_cmp = 0, n_err = 0;

  always @(posedge clk) ncyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && rd_valid) begin
      if (exp_q.size() == 0) chk("rd_spurious", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("rd_data", rd_data, e.data);
        chk("rd_latency", ncyc, e.cyc);
      end
    end
  end

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    m_wp = '0; m_rp = '0; m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  task automatic cyc(input logic w, input logic [3:0] d, input logic r);
    logic wa, ra;
    exp_t e;
    @(negedge clk);
    chk("count", count, mq.size());
    chk("full", full, mq.size() == 16);
    chk("empty", empty, mq.size() == 0);
    chk("overflow", overflow, m_ovf);
    chk("underflow", underflow, m_unf);
    wr_req = w; wr_data = d; rd_req = r;
    #1;
    wa = w && (mq.size() != 16);
    ra = r && (mq.size() != 0);
    chk("mem_wr_en", mem_wr_en, wa);
    chk("mem_rd_en", mem_rd_en, ra);
    if (wa) begin
      chk("mem_wr_addr", mem_wr_addr, m_wp[3:0]);
      chk("mem_wr_data", mem_wr_data, d);
    end
    if (ra) chk("mem_rd_addr", mem_rd_addr, m_rp[3:0]);
    m_ovf = m_ovf | (w && mq.size() == 16);
    m_unf = m_unf | (r && mq.size() == 0);
    if (ra) begin
      e.data = mq.pop_front();
      e.cyc  = ncyc + 2;
      exp_q.push_back(e);
      m_rp++;
    end
    if (wa) begin
      mq.push_back(d);
      m_wp++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 4'h0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; wr_req = 1'b0; rd_req = 1'b0; wr_data = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wr_req = 1'b0; rd_req = 1'b0; wr_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // reset then idle
    idle(3);
    chk("idle_rd_valid", rd_valid, 0);

    // fill with 1..F,0 then one rejected write
    for (int i = 1; i <= 16; i++) cyc(1'b1, 4'(i), 1'b0);
    cyc(1'b1, 4'h7, 1'b0);
    idle(1);

    // drain all 16 plus one extra read
    for (int i = 0; i < 16; i++) cyc(1'b0, 4'h0, 1'b1);
    cyc(1'b0, 4'h0, 1'b1);
    idle(3);

    // count=8, then 20 cycles of simultaneous read/write; pointers wrap past 31
    for (int i = 0; i < 8; i++) cyc(1'b1, 4'(i + 3), 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b1, 4'(i * 5 + 1), 1'b1);
    for (int i = 0; i < 8; i++) cyc(1'b0, 4'h0, 1'b1);
    idle(3);

    // full with simultaneous read: write must be rejected
    for (int i = 0; i < 16; i++) cyc(1'b1, 4'(15 - i), 1'b0);
    cyc(1'b1, 4'h9, 1'b1);
    for (int i = 0; i < 15; i++) cyc(1'b0, 4'h0, 1'b1);
    idle(3);

    // empty with simultaneous request: no fall-through
    do_reset();
    cyc(1'b1, 4'hA, 1'b1);
    cyc(1'b0, 4'h0, 1'b1);
    idle(3);

    // reset one cycle after an accepted read; the pending completion is dropped
    do_reset();
    cyc(1'b1, 4'h3, 1'b0);
    cyc(1'b1, 4'h4, 1'b0);
    cyc(1'b0, 4'h0, 1'b1);
    @(negedge clk);
    rst = 1'b1; rd_req = 1'b0;
    model_reset();
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_rd_valid", rd_valid, 0);
    @(negedge clk);
    chk("rst_hold_rd_valid", rd_valid, 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_rd_valid", rd_valid, 0);
    end
    idle(2);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
